// File: rtl/water_tank_model.sv
// water_tank_model: behavioural reservoir plant that integrates actuator flows into level sensors
//
// Ports:
//   clk                   system clock, rising edge
//   reset                 asynchronous active-high reset
//   water_supply_valvule  supply valve open (adds FILL_RATE per tick)
//   splinker_bomb         sprinkler pump on (removes SPLINKER_RATE per tick)
//   dripper_valvule       dripper valve open (removes DRIPPER_RATE per tick)
//   low_water_level       registered: level >= LOW_TH
//   mid_water_level       registered: level >= MID_TH
//   high_water_level      registered: level >= HIGH_TH
//   level                 current volume
//   overflow              one-cycle pulse after a tick whose fill was clamped at CAPACITY
//   dry_run               one-cycle pulse after a tick whose drain was clamped at 0
//   mode                  debug view: IDLE/FILLING/DRAINING/FULL/EMPTY
//
// Optional feature, macro WATER_TANK_FAULT_INJECT_EN:
//   fault_sel 01/10/11 forces the low/mid/high sensor output to fault_val after the
//   output register; 00 leaves the sensors untouched.
module water_tank_model #(
    parameter int LEVEL_W       = 8,
    parameter int CAPACITY      = 200,
    parameter int INIT_LEVEL    = 0,
    parameter int LOW_TH        = 50,
    parameter int MID_TH        = 100,
    parameter int HIGH_TH       = 150,
    parameter int FILL_RATE     = 4,
    parameter int SPLINKER_RATE = 3,
    parameter int DRIPPER_RATE  = 1,
    parameter int TICK_DIV      = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               water_supply_valvule,
    input  logic               splinker_bomb,
    input  logic               dripper_valvule,
    output logic               low_water_level,
    output logic               mid_water_level,
    output logic               high_water_level,
    output logic [LEVEL_W-1:0] level,
    output logic               overflow,
    output logic               dry_run,
    output logic [2:0]         mode
`ifdef WATER_TANK_FAULT_INJECT_EN
    ,
    input  logic [1:0]         fault_sel,
    input  logic               fault_val
`endif
);
    localparam int SW    = LEVEL_W + 3;
    localparam int CNT_W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, FILLING, DRAINING, FULL, EMPTY} mode_t;

    logic [CNT_W-1:0]   cnt;
    logic               tick;
    logic signed [SW-1:0] delta;
    logic signed [SW-1:0] next_lvl;
    logic               over;
    logic               under;
    logic [LEVEL_W-1:0] upd;
    logic               low_r;
    logic               mid_r;
    logic               high_r;
    mode_t              mode_s;

    assign tick = cnt == CNT_W'(TICK_DIV - 1);

    // Wide signed arithmetic so that fill past CAPACITY or drain below 0 never wraps
    // before the clamp decision.
    always_comb begin
        delta    = (water_supply_valvule ? SW'(FILL_RATE)     : SW'(0))
                 - (splinker_bomb        ? SW'(SPLINKER_RATE) : SW'(0))
                 - (dripper_valvule      ? SW'(DRIPPER_RATE)  : SW'(0));
        next_lvl = $signed({3'b000, level}) + delta;
        over     = next_lvl > $signed(SW'(CAPACITY));
        under    = next_lvl[SW-1];
        upd      = over ? LEVEL_W'(CAPACITY) : under ? '0 : next_lvl[LEVEL_W-1:0];
        mode_s   = level == LEVEL_W'(CAPACITY) ? FULL
                 : level == '0                 ? EMPTY
                 : delta > 0                   ? FILLING
                 : delta < 0                   ? DRAINING
                 :                               IDLE;
    end

    assign mode = mode_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            level    <= LEVEL_W'(INIT_LEVEL);
            low_r    <= INIT_LEVEL >= LOW_TH;
            mid_r    <= INIT_LEVEL >= MID_TH;
            high_r   <= INIT_LEVEL >= HIGH_TH;
            overflow <= 1'b0;
            dry_run  <= 1'b0;
        end else begin
            cnt      <= tick ? '0 : cnt + CNT_W'(1);
            overflow <= tick && over && water_supply_valvule;
            dry_run  <= tick && under;
            if (tick) begin
                level  <= upd;
                low_r  <= upd >= LEVEL_W'(LOW_TH);
                mid_r  <= upd >= LEVEL_W'(MID_TH);
                high_r <= upd >= LEVEL_W'(HIGH_TH);
            end
        end
    end

`ifdef WATER_TANK_FAULT_INJECT_EN
    // Override sits after the register so a forced sensor shows up in the same cycle.
    assign low_water_level  = fault_sel == 2'd1 ? fault_val : low_r;
    assign mid_water_level  = fault_sel == 2'd2 ? fault_val : mid_r;
    assign high_water_level = fault_sel == 2'd3 ? fault_val : high_r;
`else
    assign low_water_level  = low_r;
    assign mid_water_level  = mid_r;
    assign high_water_level = high_r;
`endif
endmodule

// File: tb/tb_water_tank_model.sv
// tb_water_tank_model: scoreboard bench for water_tank_model with TICK_DIV=4, INIT_LEVEL=0
module tb_water_tank_model;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valve = 1'b0;
    logic       pump = 1'b0;
    logic       drip = 1'b0;
    logic       low, mid, high, overflow, dry_run;
    logic [7:0] level;
    logic [2:0] mode;
`ifdef WATER_TANK_FAULT_INJECT_EN
    logic [1:0] fault_sel = 2'd0;
    logic       fault_val = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int lvl;
        bit lo;
        bit mi;
        bit hi;
        bit ov;
        bit dr;
    } exp_t;
    exp_t exp_q[$];

    water_tank_model #(.TICK_DIV(4), .INIT_LEVEL(0)) dut (
        .clk(clk),
        .reset(reset),
        .water_supply_valvule(valve),
        .splinker_bomb(pump),
        .dripper_valvule(drip),
        .low_water_level(low),
        .mid_water_level(mid),
        .high_water_level(high),
        .level(level),
        .overflow(overflow),
        .dry_run(dry_run),
        .mode(mode)
`ifdef WATER_TANK_FAULT_INJECT_EN
        ,
        .fault_sel(fault_sel),
        .fault_val(fault_val)
`endif
    );

    always #5 clk = ~clk;

    // Independent reference of where ticks fall: every 4th cycle after reset release.
    int tb_cnt;
    bit tick_prev;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tb_cnt    <= 0;
            tick_prev <= 1'b0;
        end else begin
            tb_cnt    <= tb_cnt == 3 ? 0 : tb_cnt + 1;
            tick_prev <= tb_cnt == 3;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: after a tick edge the DUT presents the new level/sensors/pulses.
    always @(negedge clk) begin
        if (!reset) begin
            if (tick_prev && exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("level", int'(level), e.lvl);
                chk("low", int'(low), int'(e.lo));
                chk("mid", int'(mid), int'(e.mi));
                chk("high", int'(high), int'(e.hi));
                chk("overflow", int'(overflow), int'(e.ov));
                chk("dry_run", int'(dry_run), int'(e.dr));
            end else if (!tick_prev) begin
                chk("overflow_between_ticks", int'(overflow), 0);
                chk("dry_run_between_ticks", int'(dry_run), 0);
            end
        end
    end

    // Drive actuators in the tick cycle and queue the hand-computed result of that tick.
    task automatic step(input bit v, input bit p, input bit d, input int lvl, input bit ov, input bit dr);
        do @(negedge clk); while (tb_cnt != 3);
        valve = v;
        pump  = p;
        drip  = d;
        exp_q.push_back('{lvl, lvl >= 50, lvl >= 100, lvl >= 150, ov, dr});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #22;
        chk("reset_level", int'(level), 0);
        chk("reset_low", int'(low), 0);
        chk("reset_mid", int'(mid), 0);
        chk("reset_high", int'(high), 0);
        chk("reset_overflow", int'(overflow), 0);
        chk("reset_dry_run", int'(dry_run), 0);
        @(negedge clk);
        reset = 1'b0;
        // Fill from empty: +4 per tick, clamps at 200 from tick 51 on with overflow each tick.
        for (int k = 1; k <= 55; k++)
            step(1, 0, 0, 4 * k > 200 ? 200 : 4 * k, 4 * k > 200, 0);
        // Net zero at capacity: no clamp, no pulse.
        step(1, 1, 1, 200, 0, 0);
        step(1, 1, 1, 200, 0, 0);
`ifdef WATER_TANK_FAULT_INJECT_EN
        @(negedge clk);
        fault_sel = 2'd2;
        fault_val = 1'b0;
        #1;
        chk("fault_low", int'(low), 1);
        chk("fault_mid", int'(mid), 0);
        chk("fault_high", int'(high), 1);
        fault_sel = 2'd0;
        #1;
        chk("fault_mid_restored", int'(mid), 1);
`endif
        // Drain -4 per tick down to 100.
        for (int k = 1; k <= 25; k++)
            step(0, 1, 1, 200 - 4 * k, 0, 0);
        // Net +1 per tick up to 120.
        for (int k = 1; k <= 20; k++)
            step(1, 1, 0, 100 + k, 0, 0);
        // Valve glitch away from the tick cycle must be ignored.
        do @(negedge clk); while (tb_cnt != 0);
        valve = 1'b0;
        pump  = 1'b0;
        @(negedge clk);
        valve = 1'b1;
        @(negedge clk);
        valve = 1'b0;
        step(0, 0, 0, 120, 0, 0);
        // Asynchronous reset mid-count at level 120.
        do @(negedge clk); while (tb_cnt != 1);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_level", int'(level), 0);
        chk("async_reset_low", int'(low), 0);
        chk("async_reset_mid", int'(mid), 0);
        chk("async_reset_high", int'(high), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        // First tick lands TICK_DIV cycles after release.
        step(1, 0, 0, 4, 0, 0);
        step(1, 0, 0, 8, 0, 0);
        step(1, 1, 0, 9, 0, 0);
        step(1, 1, 0, 10, 0, 0);
        // Drain 10,6,2,0 with dry_run on the clamping tick and every later one.
        step(0, 1, 1, 6, 0, 0);
        step(0, 1, 1, 2, 0, 0);
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 1, 0, 0, 1);
        step(0, 1, 1, 0, 0, 1);
        repeat (8) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
